// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR generator/checker pair.
// The polynomial lives here only, so generator and checker cannot drift apart.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Feedback taps: bits 4,3,2,0 XORed into the new MSB on a right shift
  localparam logic [7:0] TAP_MASK = 8'b0001_1101;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {^(s & TAP_MASK), s[7:1]};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the incoming stream, flywheels a
// reference LFSR once locked, and reports lock, per-beat errors and a count.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       expected
);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_ref, w_ref_nxt, w_pred;
  logic [3:0]       r_good, w_good_nxt, w_good_inc;
  logic [3:0]       r_bad, w_bad_nxt, w_bad_inc;
  logic             r_err_pulse, w_mismatch;
  logic [ERR_W-1:0] r_err_cnt;

  assign w_pred     = lfsr_next(r_ref);
  assign w_good_inc = r_good + 4'd1;
  assign w_bad_inc  = r_bad + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_mismatch  = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (din != '0) begin
            w_ref_nxt   = din;
            w_good_nxt  = '0;
            w_state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (din == w_pred) begin
            w_ref_nxt  = din;
            w_good_nxt = w_good_inc;
            if (w_good_inc == 4'(LOCK_CNT)) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end
          end else if (din != '0) begin
            w_ref_nxt  = din;
            w_good_nxt = '0;
          end else begin
            w_state_nxt = HUNT;
            w_good_nxt  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: din is never loaded, so a single bad byte cannot desync
          w_ref_nxt = w_pred;
          if (din == w_pred) begin
            w_bad_nxt = '0;
          end else begin
            w_mismatch = 1'b1;
            w_bad_nxt  = w_bad_inc;
            if (w_bad_inc == 4'(LOSS_CNT)) begin
              w_state_nxt = HUNT;
              w_good_nxt  = '0;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= HUNT;
      r_ref       <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref       <= w_ref_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_err_pulse <= w_mismatch;
    end
  end

  // Clear takes priority over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst || clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_mismatch && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign expected  = w_pred;

endmodule
